// File: rtl/demux_1an_rx_pkg.sv
// Shared definitions for the 1-to-N receive demultiplexer.
package demux_1an_rx_pkg;

  localparam int MODE_IMMEDIATE = 0;
  localparam int MODE_FRAME     = 1;

  // Lane pointer width; never below one bit, since LANES is at least 2.
  function automatic int sel_width(input int lanes);
    return (lanes <= 2) ? 1 : $clog2(lanes);
  endfunction

  // Low bit of a lane's slice in the flat data_out bus.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/demux_lane_ptr.sv
// Wrapping lane pointer. Realign has priority and resets the pointer to lane 0.
module demux_lane_ptr
  import demux_1an_rx_pkg::*;
#(
  parameter  int LANES = 2,
  localparam int SELW  = sel_width(LANES)
) (
  input  logic            clk_2f,
  input  logic            reset_L,
  input  logic            valid_in,
  input  logic            align_in,
  output logic [SELW-1:0] sel,
  output logic            wrap
);

  localparam logic [SELW-1:0] TOP = SELW'(LANES - 1);

  // Advance on each accepted word; wrap pulses the cycle after the top lane is taken.
  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      sel  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= valid_in && !align_in && (sel == TOP);
      if (align_in)
        sel <= valid_in ? SELW'(1) : '0;
      else if (valid_in)
        sel <= (sel == TOP) ? '0 : sel + SELW'(1);
    end
  end

endmodule

// File: rtl/demux_1an_rx.sv
// 1-to-N round-robin receive demultiplexer with realign and optional frame release.
module demux_1an_rx
  import demux_1an_rx_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int LANES   = 2,
  parameter  int ALIGNED = MODE_IMMEDIATE,
  localparam int SELW    = sel_width(LANES)
) (
  input  logic                   clk_2f,
  input  logic                   reset_L,
  input  logic                   valid_in,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   align_in,
  output logic [LANES-1:0]       valid_out,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic [SELW-1:0]        sel_out,
  output logic                   frame_done
);

  localparam logic [SELW-1:0] TOP = SELW'(LANES - 1);

  logic [SELW-1:0] sel;
  logic            wrap;
  logic [SELW-1:0] lane;

  // A realigned word always lands in lane 0 regardless of the old pointer.
  assign lane       = align_in ? '0 : sel;
  assign sel_out    = sel;
  assign frame_done = wrap;

  demux_lane_ptr #(.LANES(LANES)) u_ptr (
    .clk_2f   (clk_2f),
    .reset_L  (reset_L),
    .valid_in (valid_in),
    .align_in (align_in),
    .sel      (sel),
    .wrap     (wrap)
  );

  if (ALIGNED == MODE_FRAME) begin : g_frame
    logic [WIDTH-1:0] stage [LANES-1];
    logic [LANES-2:0] stage_vld;
    logic             top_hit;

    assign top_hit = valid_in && !align_in && (sel == TOP);

    // Stage lanes 0..LANES-2, then release the whole frame with the top-lane word.
    always_ff @(posedge clk_2f) begin
      if (!reset_L) begin
        valid_out <= '0;
        data_out  <= '0;
        stage_vld <= '0;
        for (int i = 0; i < LANES - 1; i++) stage[i] <= '0;
      end else begin
        valid_out <= '0;
        if (align_in) stage_vld <= '0;
        if (top_hit) begin
          if (&stage_vld) begin
            for (int i = 0; i < LANES - 1; i++)
              data_out[lane_lo(i, WIDTH) +: WIDTH] <= stage[i];
            data_out[lane_lo(LANES - 1, WIDTH) +: WIDTH] <= data_in;
            valid_out <= '1;
          end
          stage_vld <= '0;
        end else if (valid_in) begin
          for (int i = 0; i < LANES - 1; i++) begin
            if (lane == SELW'(i)) begin
              stage[i]     <= data_in;
              stage_vld[i] <= 1'b1;
            end
          end
        end
      end
    end
  end else begin : g_immediate
    // Each word goes straight to its lane; lanes keep their last value when idle.
    always_ff @(posedge clk_2f) begin
      if (!reset_L) begin
        valid_out <= '0;
        data_out  <= '0;
      end else begin
        for (int i = 0; i < LANES; i++) begin
          valid_out[i] <= valid_in && (lane == SELW'(i));
          if (valid_in && (lane == SELW'(i)))
            data_out[lane_lo(i, WIDTH) +: WIDTH] <= data_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_1an_rx.sv
// Directed bench for demux_1an_rx across several lane counts and both release modes.
module tb_demux_1an_rx;

  logic       clk_2f = 1'b0;
  logic       reset_L = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       align_in = 1'b0;

  int checks = 0;
  int errors = 0;

  // LANES=2 immediate
  logic [1:0]  v2; logic [15:0] d2; logic [0:0] s2; logic f2;
  // LANES=4 immediate
  logic [3:0]  v4; logic [31:0] d4; logic [1:0] s4; logic f4;
  // LANES=4 frame mode
  logic [3:0]  vf; logic [31:0] df; logic [1:0] sf; logic ff;
  // LANES=3 immediate
  logic [2:0]  v3; logic [23:0] d3; logic [1:0] s3; logic f3;

  always #5 clk_2f = ~clk_2f;

  demux_1an_rx #(.WIDTH(8), .LANES(2), .ALIGNED(0)) u_l2 (
    .clk_2f(clk_2f), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .align_in(align_in), .valid_out(v2), .data_out(d2), .sel_out(s2), .frame_done(f2));

  demux_1an_rx #(.WIDTH(8), .LANES(4), .ALIGNED(0)) u_l4 (
    .clk_2f(clk_2f), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .align_in(align_in), .valid_out(v4), .data_out(d4), .sel_out(s4), .frame_done(f4));

  demux_1an_rx #(.WIDTH(8), .LANES(4), .ALIGNED(1)) u_l4f (
    .clk_2f(clk_2f), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .align_in(align_in), .valid_out(vf), .data_out(df), .sel_out(sf), .frame_done(ff));

  demux_1an_rx #(.WIDTH(8), .LANES(3), .ALIGNED(0)) u_l3 (
    .clk_2f(clk_2f), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .align_in(align_in), .valid_out(v3), .data_out(d3), .sel_out(s3), .frame_done(f3));

  // Apply inputs, take one edge, and settle just after it.
  task automatic drive(input logic v, input logic [7:0] d, input logic a);
    valid_in = v; data_in = d; align_in = a;
    @(posedge clk_2f); #1;
  endtask

  task automatic do_reset(input int cycles);
    reset_L = 1'b0; valid_in = 1'b0; align_in = 1'b0; data_in = 8'h00;
    repeat (cycles) begin @(posedge clk_2f); #1; end
    reset_L = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(2);
    checks++;
    if ({v2, d2, s2, f2} !== '0) begin
      errors++; $display("FAIL reset_l2 got v=%b d=%h s=%0d f=%b want zeros", v2, d2, s2, f2);
    end
    checks++;
    if ({vf, df, sf, ff} !== '0) begin
      errors++; $display("FAIL reset_l4f got v=%b d=%h s=%0d f=%b want zeros", vf, df, sf, ff);
    end
  endtask

  task automatic test_immediate_l2;
    logic [7:0]  din  [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [1:0]  ev   [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] ed   [4] = '{16'h00A1, 16'hB2A1, 16'hB2C3, 16'hD4C3};
    logic        ef   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        es   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, din[i], 1'b0);
      checks++;
      if (v2 !== ev[i] || d2 !== ed[i] || f2 !== ef[i] || s2 !== es[i]) begin
        errors++;
        $display("FAIL imm_l2[%0d] got v=%b d=%h f=%b s=%0d want v=%b d=%h f=%b s=%0d",
                 i, v2, d2, f2, s2, ev[i], ed[i], ef[i], es[i]);
      end
    end
    drive(1'b0, 8'hEE, 1'b0);
    checks++;
    if (v2 !== 2'b00 || d2 !== 16'hD4C3 || f2 !== 1'b0) begin
      errors++; $display("FAIL imm_l2_idle got v=%b d=%h f=%b want v=00 d=d4c3 f=0", v2, d2, f2);
    end
  endtask

  task automatic test_bubbles;
    logic       vin [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] din [7] = '{8'h11, 8'h00, 8'h00, 8'h22, 8'h33, 8'h00, 8'h44};
    logic [1:0] es  [7] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
    logic [3:0] ev  [7] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b1000};
    logic [31:0] ed [7] = '{32'h00000011, 32'h00000011, 32'h00000011, 32'h00002211,
                            32'h00332211, 32'h00332211, 32'h44332211};
    logic       ef  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      drive(vin[i], din[i], 1'b0);
      checks++;
      if (s4 !== es[i] || v4 !== ev[i] || d4 !== ed[i] || f4 !== ef[i]) begin
        errors++;
        $display("FAIL bubbles[%0d] got s=%0d v=%b d=%h f=%b want s=%0d v=%b d=%h f=%b",
                 i, s4, v4, d4, f4, es[i], ev[i], ed[i], ef[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] din [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h12, 8'h13, 8'h14};
    logic [1:0] es;
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, din[i], 1'b0);
      es = 2'((i + 1) % 4);
      checks++;
      if (i == 3) begin
        if (vf !== 4'b1111 || df !== 32'h04030201 || ff !== 1'b1 || sf !== es) begin
          errors++; $display("FAIL frame_rel1 got v=%b d=%h f=%b s=%0d want v=1111 d=04030201 f=1 s=0", vf, df, ff, sf);
        end
      end else if (i == 7) begin
        if (vf !== 4'b1111 || df !== 32'h14131211 || ff !== 1'b1 || sf !== es) begin
          errors++; $display("FAIL frame_rel2 got v=%b d=%h f=%b s=%0d want v=1111 d=14131211 f=1 s=0", vf, df, ff, sf);
        end
      end else begin
        if (vf !== 4'b0000 || ff !== 1'b0 || sf !== es || df !== (i < 3 ? 32'h0 : 32'h04030201)) begin
          errors++; $display("FAIL frame_hold[%0d] got v=%b d=%h f=%b s=%0d want v=0000 f=0 s=%0d", i, vf, df, ff, sf, es);
        end
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    checks++;
    if (vf !== 4'b0000 || ff !== 1'b0 || df !== 32'h14131211) begin
      errors++; $display("FAIL frame_idle got v=%b d=%h f=%b want v=0000 d=14131211 f=0", vf, df, ff);
    end
  endtask

  task automatic test_realign;
    logic       vin [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] din [6] = '{8'h01, 8'h02, 8'h05, 8'h06, 8'h07, 8'h08};
    logic       ain [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] es  [6] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      drive(vin[i], din[i], ain[i]);
      checks++;
      if (i == 5) begin
        if (vf !== 4'b1111 || df !== 32'h08070605 || ff !== 1'b1 || sf !== es[i]) begin
          errors++; $display("FAIL realign_rel got v=%b d=%h f=%b s=%0d want v=1111 d=08070605 f=1 s=0", vf, df, ff, sf);
        end
      end else if (vf !== 4'b0000 || df !== 32'h0 || ff !== 1'b0 || sf !== es[i]) begin
        errors++;
        $display("FAIL realign_hold[%0d] got v=%b d=%h f=%b s=%0d want v=0000 d=0 f=0 s=%0d", i, vf, df, ff, sf, es[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset(1);
    drive(1'b1, 8'h31, 1'b0);
    drive(1'b1, 8'h32, 1'b0);
    checks++;
    if (d3 !== 24'h003231 || s3 !== 2'd2) begin
      errors++; $display("FAIL mid_pre got d=%h s=%0d want d=003231 s=2", d3, s3);
    end
    reset_L = 1'b0; valid_in = 1'b1; data_in = 8'h55;
    @(posedge clk_2f); #1;
    reset_L = 1'b1;
    checks++;
    if ({v3, d3, s3, f3} !== '0) begin
      errors++; $display("FAIL mid_reset got v=%b d=%h s=%0d f=%b want zeros", v3, d3, s3, f3);
    end
    drive(1'b1, 8'h9A, 1'b0);
    checks++;
    if (v3 !== 3'b001 || d3 !== 24'h00009A || s3 !== 2'd1 || f3 !== 1'b0) begin
      errors++; $display("FAIL mid_after got v=%b d=%h s=%0d f=%b want v=001 d=00009a s=1 f=0", v3, d3, s3, f3);
    end
  endtask

  task automatic test_wrap_odd;
    logic [1:0]  es [7] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    logic [2:0]  ev [7] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    logic [23:0] ed [7] = '{24'h000001, 24'h000201, 24'h030201, 24'h030204,
                            24'h030504, 24'h060504, 24'h060507};
    int pulses = 0;
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 8'(i + 1), 1'b0);
      if (f3 === 1'b1) pulses++;
      checks++;
      if (s3 !== es[i] || v3 !== ev[i] || d3 !== ed[i] || f3 !== (i == 2 || i == 5)) begin
        errors++;
        $display("FAIL wrap3[%0d] got s=%0d v=%b d=%h f=%b want s=%0d v=%b d=%h",
                 i, s3, v3, d3, f3, es[i], ev[i], ed[i]);
      end
    end
    checks++;
    if (pulses !== 2) begin
      errors++; $display("FAIL wrap3_pulses got %0d want 2", pulses);
    end
  endtask

  initial begin
    test_reset;
    test_immediate_l2;
    test_bubbles;
    test_back_to_back;
    test_realign;
    test_reset_mid;
    test_wrap_odd;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
